// File: rtl/shared_counter_arbiter_pkg.sv
// Shared types for the shared-counter arbiter: opcodes, FSM states and requester ids.
package shared_counter_arbiter_pkg;

  typedef enum logic [1:0] {
    OpLoad = 2'b00,
    OpInc  = 2'b01,
    OpDec  = 2'b10,
    OpNop  = 2'b11
  } op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StExec = 1'b1
  } state_e;

  typedef enum logic {
    Req1 = 1'b0,
    Req2 = 1'b1
  } req_id_e;

  function automatic req_id_e other_req(req_id_e id);
    return (id == Req1) ? Req2 : Req1;
  endfunction

endpackage

// File: rtl/shared_counter_arbiter_if.sv
// Requester handshakes plus the counter's read value and two write ports.
interface shared_counter_arbiter_if
  import shared_counter_arbiter_pkg::*;
#(
  parameter int unsigned Width = 9
) ();

  logic             req1;
  op_e              op1;
  logic [Width-1:0] data1;
  logic             ack1;

  logic             req2;
  op_e              op2;
  logic [Width-1:0] data2;
  logic             ack2;

  logic [Width-1:0] value;
  logic             wr1;
  logic [Width-1:0] wrdata1;
  logic             wr2;
  logic [Width-1:0] wrdata2;
  logic             busy;

  // Arbiter side.
  modport slave (
    input  req1, op1, data1, req2, op2, data2, value,
    output ack1, ack2, wr1, wrdata1, wr2, wrdata2, busy
  );

  // Requesters and counter side.
  modport master (
    output req1, op1, data1, req2, op2, data2, value,
    input  ack1, ack2, wr1, wrdata1, wr2, wrdata2, busy
  );

endinterface

// File: rtl/shared_counter_arbiter_counter_op_alu.sv
// Combinational next-value for a counter op; wr_en_o is low for NOP.
module counter_op_alu
  import shared_counter_arbiter_pkg::*;
#(
  parameter int unsigned Width = 9
) (
  input  op_e              op_i,
  input  logic [Width-1:0] data_i,
  input  logic [Width-1:0] value_i,
  output logic [Width-1:0] next_o,
  output logic             wr_en_o
);

  always_comb begin
    next_o  = value_i;
    wr_en_o = 1'b1;
    unique case (op_i)
      OpLoad: next_o = data_i;
      OpInc:  next_o = value_i + Width'(1);
      OpDec:  next_o = value_i - Width'(1);
      OpNop:  wr_en_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/shared_counter_arbiter.sv
// Round-robin arbiter serialising two requesters onto a two-port shared counter,
// driving exactly one write port per operation.
module shared_counter_arbiter
  import shared_counter_arbiter_pkg::*;
#(
  parameter int unsigned Width = 9
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  shared_counter_arbiter_if.slave bus
);

  state_e           state_q;
  req_id_e          prio_q;
  req_id_e          gnt_q;
  req_id_e          gnt_d;
  op_e              op_q;
  op_e              op_d;
  logic [Width-1:0] data_q;
  logic [Width-1:0] data_d;
  logic             ack1_q;
  logic             ack2_q;
  logic             busy_q;
  logic             any_req;
  logic [Width-1:0] alu_next;
  logic             alu_wr_en;

  assign any_req = bus.req1 | bus.req2;

  always_comb begin
    gnt_d = Req1;
    if (bus.req1 && bus.req2) begin
      gnt_d = prio_q;
    end else if (bus.req2) begin
      gnt_d = Req2;
    end
    op_d   = (gnt_d == Req1) ? bus.op1 : bus.op2;
    data_d = (gnt_d == Req1) ? bus.data1 : bus.data2;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      prio_q  <= Req1;
      gnt_q   <= Req1;
      op_q    <= OpLoad;
      data_q  <= '0;
      ack1_q  <= 1'b0;
      ack2_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q <= StExec;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
            busy_q  <= 1'b1;
            ack1_q  <= (gnt_d == Req1);
            ack2_q  <= (gnt_d == Req2);
          end
        end
        StExec: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          ack1_q  <= 1'b0;
          ack2_q  <= 1'b0;
          prio_q  <= other_req(gnt_q);
        end
      endcase
    end
  end

  // One ALU serves both ports: only the granted port ever sees its result.
  counter_op_alu #(
    .Width(Width)
  ) u_alu (
    .op_i   (op_q),
    .data_i (data_q),
    .value_i(bus.value),
    .next_o (alu_next),
    .wr_en_o(alu_wr_en)
  );

  assign bus.ack1    = ack1_q;
  assign bus.ack2    = ack2_q;
  assign bus.busy    = busy_q;
  assign bus.wr1     = ack1_q & alu_wr_en;
  assign bus.wr2     = ack2_q & alu_wr_en;
  assign bus.wrdata1 = ack1_q ? alu_next : '0;
  assign bus.wrdata2 = ack2_q ? alu_next : '0;

  wr_exclusive_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus.wr1 && bus.wr2));

  ack_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus.ack1 && bus.ack2));

  exec_one_cycle_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    busy_q |=> !busy_q);

endmodule

// File: tb/tb_shared_counter_arbiter.sv
// Directed bench for shared_counter_arbiter: expected writes queued at issue, checked by a monitor.
module tb_shared_counter_arbiter;
  import shared_counter_arbiter_pkg::*;

  localparam int unsigned W = 9;

  typedef struct {
    int         port;
    bit         wr;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [W-1:0] cnt = '0;
  exp_t sb_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shared_counter_arbiter_if #(.Width(W)) bus ();

  shared_counter_arbiter #(
    .Width(W)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Shared counter model: the arbiter guarantees at most one write port is active.
  always @(posedge clk) begin
    if (bus.wr1) cnt <= bus.wrdata1;
    else if (bus.wr2) cnt <= bus.wrdata2;
  end
  assign bus.value = cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (bus.wr1 || bus.wr2) check("wr_exclusive", 32'(bus.wr1 & bus.wr2), 32'd0);
      if (bus.ack1 || bus.ack2) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack1=%0b ack2=%0b, want none", bus.ack1, bus.ack2);
        end else begin
          e = sb_q.pop_front();
          check("ack_port", 32'({bus.ack1, bus.ack2}), (e.port == 1) ? 32'd2 : 32'd1);
          check("busy", 32'(bus.busy), 32'd1);
          if (e.port == 1) begin
            check("wr1", 32'(bus.wr1), 32'(e.wr));
            check("idle_port2", 32'({bus.wr2, bus.wrdata2}), 32'd0);
            if (e.wr) check("wrdata1", 32'(bus.wrdata1), 32'(e.data));
          end else begin
            check("wr2", 32'(bus.wr2), 32'(e.wr));
            check("idle_port1", 32'({bus.wr1, bus.wrdata1}), 32'd0);
            if (e.wr) check("wrdata2", 32'(bus.wrdata2), 32'(e.data));
          end
        end
      end
    end
  end

  task automatic set_req(input int port, input bit req, input op_e op, input logic [W-1:0] d);
    if (port == 1) begin
      bus.req1 = req; bus.op1 = op; bus.data1 = d;
    end else begin
      bus.req2 = req; bus.op2 = op; bus.data2 = d;
    end
  endtask

  task automatic wait_ack(input int port);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (port == 1) ? bus.ack1 : bus.ack2;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack%0d within 20 cycles, want ack", port);
    end
  endtask

  task automatic run_op(input int port, input op_e op, input logic [W-1:0] d,
                        input bit exp_wr, input logic [W-1:0] exp_data);
    sb_q.push_back('{port, exp_wr, exp_data});
    @(posedge clk); #1;
    set_req(port, 1'b1, op, d);
    wait_ack(port);
    @(posedge clk); #1;
    set_req(port, 1'b0, OpNop, '0);
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.ack1, bus.ack2, bus.wr1, bus.wr2, bus.busy, bus.wrdata1, bus.wrdata2});
  endfunction

  initial begin
    int evt;
    int n;
    bit got;
    rst_n = 1'b0;
    set_req(1, 1'b0, OpNop, '0);
    set_req(2, 1'b0, OpNop, '0);

    repeat (3) @(posedge clk);
    #1 check("reset_outs", outs(), 32'd0);
    #2 rst_n = 1'b1;

    // Asynchronous pulse mid-cycle, then a quiet idle window.
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check("async_rst_outs", outs(), 32'd0);
    #1 rst_n = 1'b1;
    evt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.ack1 || bus.ack2 || bus.wr1 || bus.wr2) evt++;
    end
    check("idle_quiet", 32'(evt), 32'd0);

    run_op(1, OpLoad, 9'h155, 1'b1, 9'h155);
    check("cnt_load", 32'(cnt), 32'h155);

    run_op(1, OpLoad, 9'h1FF, 1'b1, 9'h1FF);
    run_op(2, OpInc, 9'h000, 1'b1, 9'h000);
    check("cnt_inc_wrap", 32'(cnt), 32'h000);
    run_op(2, OpDec, 9'h000, 1'b1, 9'h1FF);
    check("cnt_dec_wrap", 32'(cnt), 32'h1FF);
    // Requester 2 served last, so requester 1 has priority next.
    run_op(2, OpLoad, 9'h000, 1'b1, 9'h000);
    check("cnt_zero", 32'(cnt), 32'h000);

    // Both held: grants must alternate 1,2,1,2 with values 1..8.
    for (int i = 0; i < 8; i++) sb_q.push_back('{(i % 2 == 0) ? 1 : 2, 1'b1, W'(i + 1)});
    @(posedge clk); #1;
    set_req(1, 1'b1, OpInc, '0);
    set_req(2, 1'b1, OpInc, '0);
    n = 0;
    for (int i = 0; i < 80 && n < 8; i++) begin
      @(negedge clk);
      if (bus.ack1 || bus.ack2) n++;
    end
    check("fair_ops", 32'(n), 32'd8);
    @(posedge clk); #1;
    set_req(1, 1'b0, OpNop, '0);
    set_req(2, 1'b0, OpNop, '0);
    @(posedge clk); #1;
    check("cnt_fair", 32'(cnt), 32'd8);

    run_op(1, OpNop, 9'h000, 1'b0, 9'h000);
    check("cnt_nop", 32'(cnt), 32'd8);

    // Reset during EXEC of requester 2 (which now holds priority).
    @(posedge clk); #1;
    set_req(2, 1'b1, OpLoad, 9'h0AA);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #2;
      got = bus.busy;
    end
    check("exec_reached", 32'(got), 32'd1);
    rst_n = 1'b0;
    #1 check("midop_rst_outs", outs(), 32'd0);
    set_req(2, 1'b0, OpNop, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("cnt_abandoned", 32'(cnt), 32'd8);

    // Prio must be back on requester 1.
    sb_q.push_back('{1, 1'b1, 9'h011});
    sb_q.push_back('{2, 1'b1, 9'h022});
    @(posedge clk); #1;
    set_req(1, 1'b1, OpLoad, 9'h011);
    set_req(2, 1'b1, OpLoad, 9'h022);
    wait_ack(1);
    @(posedge clk); #1;
    set_req(1, 1'b0, OpNop, '0);
    wait_ack(2);
    @(posedge clk); #1;
    set_req(2, 1'b0, OpNop, '0);
    check("cnt_final", 32'(cnt), 32'h022);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_counter_arbiter.md
Name: shared_counter_arbiter

Overview:
- Sits in front of the two-port shared counter and makes every write exclusive.
- Two requester processes submit LOAD/INC/DEC/NOP operations. The arbiter grants one at a time, round-robin, and computes the new value from the counter's current value.
- It drives exactly one of the counter's write ports per operation, so the counter never sees simultaneous writes and never ORs data.

Parameters:
- WIDTH, 9, counter and data width in bits.

Ports:
- clk  input  1  system clock, rising edge
- nrst  input  1  reset, asynchronous, active-low
- req1  input  1  requester 1 operation request; held until ack1
- op1  input  2  requester 1 opcode: 00 LOAD, 01 INC, 10 DEC, 11 NOP
- data1  input  WIDTH  requester 1 load data; used only for LOAD
- ack1  output  1  one-cycle pulse: requester 1 operation performed
- req2, op2, data2, ack2  same as requester 1, for requester 2
- value  input  WIDTH  current counter value
- wr1  output  1  counter write enable, port 1 (driven for requester 1)
- wrdata1  output  WIDTH  counter write data, port 1
- wr2  output  1  counter write enable, port 2 (driven for requester 2)
- wrdata2  output  WIDTH  counter write data, port 2
- busy  output  1  high while an operation is in flight (EXEC state)

Behaviour:
- Clock and reset: one clock (clk). Reset nrst is asynchronous and active-low.
- Reset values: state=IDLE; prio=requester 1 preferred; all of ack1, ack2, wr1, wr2, busy are 0; wrdata1, wrdata2 and the latched op/data registers are 0.
- States are IDLE and EXEC.
- IDLE, neither req asserted: stay in IDLE.
- IDLE, one req asserted: latch that requester's id, op and data. Go to EXEC.
- IDLE, both req asserted: grant the requester named by prio. Latch as above and go to EXEC.
- EXEC, one cycle long:
  - busy=1.
  - ack of the granted requester = 1.
  - wr of the granted port = 1, unless the latched op is NOP; then no wr, ack still pulses.
  - wrdata of the granted port = next value. Other port: wr=0, wrdata=0.
  - Next cycle: back to IDLE. prio flips to the requester not just served.
- Next value:
  - LOAD: latched data.
  - INC: value+1, modulo 2^WIDTH (all-ones wraps to 0).
  - DEC: value-1, modulo 2^WIDTH (0 wraps to all-ones).
  - Computed from value sampled in the EXEC cycle.
- Latency and throughput:
  - Request seen in IDLE at edge N; wr and ack high during cycle N+1.
  - The counter updates at edge N+2.
  - Maximum throughput is one operation per 2 cycles. The IDLE gap guarantees value reflects the prior write before the next EXEC.
- Handshake:
  - A requester holds req, op and data stable until it sees ack. It drops req in the cycle after ack, or keeps it high to request again.
  - op and data are latched at grant; changes after grant are ignored.
  - A req dropped before grant is simply never served; no ack is issued.
- Fairness: with both reqs held continuously, grants alternate 1,2,1,2. No requester waits more than one other operation.
- Exclusivity invariant: wr1 and wr2 are never both 1 in any cycle.
- Reset mid-operation: asserting nrst during EXEC clears wr, ack and busy immediately. The operation is abandoned: no ack, counter not written by the arbiter.

Decomposition:
- shared_counter_pkg:
  - opcode constants OP_LOAD, OP_INC, OP_DEC, OP_NOP;
  - state encoding ST_IDLE, ST_EXEC;
  - requester-id constants REQ1, REQ2.
- One sub-module, counter_op_alu: combinational (op, data, value) -> next value and write-enable qualifier. It is shared by both ports' write paths.

Test Plan:
- Reset, no requests; pulse nrst low asynchronously mid-cycle -> all outputs 0 immediately; no wr or ack for 20 cycles.
- req1, LOAD 9'h155 -> cycle N+1: wr1=1, wrdata1=9'h155, ack1=1, wr2=0. Counter reads 9'h155 after.
- Counter=9'h1FF, req2 INC -> wrdata2=9'h000. Then req2 DEC -> wrdata2=9'h1FF. Both ops wrap.
- req1 and req2 both held INC from counter=0 for 8 operations -> acks alternate 1,2,1,…; final value 8; wr1&wr2 never both 1.
- req1 NOP -> ack1 pulses; wr1=0, wr2=0; counter unchanged.
- nrst asserted during the EXEC of req2 LOAD 9'h0AA -> wr2 and ack2 drop at once. After release, state=IDLE and prio favours requester 1.
